// File: rtl/elastic_fifo_inner_occ_if.sv
// Handshake bundle for elastic_fifo_inner_occ.
//   ins/ins_valid/ins_ready    : write side (producer -> FIFO)
//   outs/outs_valid/outs_ready : read side (FIFO -> consumer)
// The master modport is the environment that drives the FIFO.
// The slave modport is the FIFO itself.
interface elastic_fifo_inner_occ_if #(
  parameter int DATA_TYPE = 32
);
  logic [DATA_TYPE-1:0] ins;
  logic                 ins_valid;
  logic                 ins_ready;
  logic [DATA_TYPE-1:0] outs;
  logic                 outs_valid;
  logic                 outs_ready;

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );
endinterface

// File: rtl/elastic_fifo_inner_occ.sv
// Elastic FIFO with an occupancy counter. Any depth of 2 or more is
// supported; NUM_SLOTS does not have to be a power of two.
// Ports:
//   clk         : rising-edge clock
//   rst         : asynchronous active-low reset (0 = reset)
//   bus         : write and read handshakes (slave modport)
//   count       : current occupancy, 0..NUM_SLOTS
//   almost_full : count >= AFULL_LEVEL
// Full and empty are decoded from count. No separate flags are kept.
// A write into an empty FIFO becomes visible one cycle later. There is no
// bypass path from ins to outs.
module elastic_fifo_inner_occ #(
  parameter  int DATA_TYPE   = 32,
  parameter  int NUM_SLOTS   = 4,
  parameter  int AFULL_LEVEL = NUM_SLOTS - 1,
  localparam int CW          = $clog2(NUM_SLOTS + 1),
  localparam int PW          = ($clog2(NUM_SLOTS) < 1) ? 1 : $clog2(NUM_SLOTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  elastic_fifo_inner_occ_if.slave bus,
  output logic [CW-1:0]           count,
  output logic                    almost_full
);

  // Stop elaboration when a parameter value is out of range.
  if (NUM_SLOTS < 2) begin : g_bad_depth
    $fatal(1, "elastic_fifo_inner_occ: NUM_SLOTS must be >= 2");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > NUM_SLOTS) begin : g_bad_afull
    $fatal(1, "elastic_fifo_inner_occ: AFULL_LEVEL must be in 1..NUM_SLOTS");
  end
  if (DATA_TYPE < 1) begin : g_bad_width
    $fatal(1, "elastic_fifo_inner_occ: DATA_TYPE must be >= 1");
  end

  logic [DATA_TYPE-1:0] mem [NUM_SLOTS];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic                 full;
  logic                 empty;
  logic                 write;
  logic                 read;

  assign full  = (count == CW'(NUM_SLOTS));
  assign empty = (count == '0);

  // A full FIFO can still accept a write when the head leaves in the same
  // cycle.
  assign bus.ins_ready  = ~full | bus.outs_ready;
  assign bus.outs_valid = ~empty;
  assign bus.outs       = mem[head];
  assign almost_full    = (count >= CW'(AFULL_LEVEL));

  assign write = bus.ins_valid & bus.ins_ready;
  assign read  = bus.outs_valid & bus.outs_ready;

  // Wrap by explicit compare. This keeps the pointer correct when
  // NUM_SLOTS is not a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    ptr_next = (ptr == PW'(NUM_SLOTS - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // Storage is not reset. After reset, head == tail and count == 0, so no
  // stale entry can ever be presented as valid.
  always_ff @(posedge clk) begin
    if (write) begin
      mem[tail] <= bus.ins;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (write) begin
        tail <= ptr_next(tail);
      end
      if (read) begin
        head <= ptr_next(head);
      end
      unique case ({write, read})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/elastic_fifo_inner_occ.md
ELASTIC_FIFO_INNER_OCC -- requirements
Module: elastic_fifo_inner_occ

Interface
REQ-001 SHALL have parameter DATA_TYPE, default 32, meaning payload width in bits (>=1).
REQ-002 SHALL have parameter NUM_SLOTS, default 4, meaning storage depth in entries (>=2, any integer, not restricted to powers of two).
REQ-003 SHALL have parameter AFULL_LEVEL, default NUM_SLOTS-1, meaning occupancy at or above which almost_full asserts (1..NUM_SLOTS).
REQ-004 SHALL define CW = $clog2(NUM_SLOTS+1) and PW = max(1,$clog2(NUM_SLOTS)).
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port: clk  input  1  rising-edge clock.
REQ-007 SHALL have port: rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-008 SHALL have port: ins  input  DATA_TYPE  write payload.
REQ-009 SHALL have port: ins_valid  input  1  producer offers ins.
REQ-010 SHALL have port: ins_ready  output  1  FIFO accepts ins this cycle.
REQ-011 SHALL have port: outs  output  DATA_TYPE  head-entry payload.
REQ-012 SHALL have port: outs_valid  output  1  head entry present.
REQ-013 SHALL have port: outs_ready  input  1  consumer takes head this cycle.
REQ-014 SHALL have port: count  output  CW  current occupancy, 0..NUM_SLOTS.
REQ-015 SHALL have port: almost_full  output  1  count >= AFULL_LEVEL.

Function
REQ-016 SHALL define read = outs_valid & outs_ready and write = ins_valid & ins_ready.
REQ-017 SHALL drive ins_ready = ~full | outs_ready, so a write into a full FIFO is accepted in the same cycle as a read.
REQ-018 SHALL drive outs_valid = ~empty, registered state only, with no combinational path from ins_valid.
REQ-019 SHALL drive outs from the storage entry at Head; outs is don't-care while outs_valid=0.
REQ-020 SHALL have a write latency of 1 cycle: an entry written into an empty FIFO at edge N is presented with outs_valid=1 after edge N, with no same-cycle bypass.
REQ-021 SHALL store ins at Tail on write and advance Tail on write, and advance Head on read.
REQ-022 SHALL wrap each pointer by explicit compare (ptr == NUM_SLOTS-1 -> 0, else ptr+1), never by modulo of a truncated sum, and SHALL be correct for non-power-of-two depths.
REQ-023 SHALL update the count register as follows: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-024 SHALL derive full = (count == NUM_SLOTS) and empty = (count == 0) from count; the designs SHALL hold no independent full/empty flags.
REQ-025 SHALL, on simultaneous read and write, write to Tail and read from Head in the same edge, advance both pointers, and leave count unchanged; this SHALL hold at full and at count=1.
REQ-026 SHALL NOT, at empty, let a simultaneous write pass through; the entry becomes visible next cycle per REQ-020.
REQ-027 SHALL preserve order: the outs sequence SHALL equal the accepted ins sequence with no loss or duplication.
REQ-028 SHALL drive almost_full combinationally from count.
REQ-029 SHALL be safe when ins_valid is deasserted without acceptance; it SHALL write only on write.

Reset
REQ-030 SHALL, while rst=0, force Head=0, Tail=0 and count=0 asynchronously, so outs_valid=0, ins_ready=1 and almost_full=0 (AFULL_LEVEL>=1).
REQ-031 SHALL NOT reset the storage array, and outs is undefined after reset until the first write.
REQ-032 SHALL discard all contents when reset is asserted mid-operation and SHALL drop any handshake in that cycle.
REQ-033 SHALL make the first accepted write valid at the first rising edge with rst=1.

Verification
REQ-034 SHALL pass this check: NUM_SLOTS=4, write 0xA1..0xA4 with outs_ready=0 -> count=4, almost_full=1 after 3rd write, ins_ready=0; then outs_ready=1 -> outs A1,A2,A3,A4 on consecutive cycles, count back to 0.
REQ-035 SHALL pass this check: full FIFO, ins_valid=1, outs_ready=1 for 10 cycles -> one write and one read each cycle, count stays 4, output order is preserved.
REQ-036 SHALL pass this check: NUM_SLOTS=3, stream 20 entries with random valid/ready -> Head/Tail wrap 2->0 correctly, scoreboard matches, and count never exceeds 3.
REQ-037 SHALL pass this check: empty FIFO, write 0x55 at edge N with outs_ready=1 -> outs_valid=0 in cycle N, outs_valid=1 with outs=0x55 after edge N, read after edge N+1, count 0.
REQ-038 SHALL pass this check: count=2, assert rst=0 asynchronously between edges -> outs_valid=0 and count=0 immediately; release -> next write is output first.
REQ-039 SHALL pass this check: NUM_SLOTS=1 rejected at elaboration, NUM_SLOTS=2 passes REQ-034 to REQ-035 scaled to depth 2.
